regr_point_sampler: RTL and testbench

//  Upstream feeder for the line-fit stage. Scans the per-pixel colour-mask stream, emits (x,y) of

---
 rtl/regr_point_sampler_pkg.sv | 20 ++
 rtl/regr_point_sampler.sv | 199 +++++++++++++++++++
 tb/tb_regr_point_sampler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regr_point_sampler_pkg.sv
// Shared types and widths for the regression point sampler.
//   state_e : sampler frame state (IDLE / COLLECT / TAB / WAIT_RESULT)
//   X_W, Y_W : pixel coordinate widths
//   PCNT_W  : emitted-point counter width
//   HCNT_W  : accepted-hit counter width (wraps)
package regr_point_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_COLLECT     = 2'd1,
    ST_TAB         = 2'd2,
    ST_WAIT_RESULT = 2'd3
  } state_e;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int PCNT_W = 14;
  localparam int HCNT_W = 21;

endpackage

// File: rtl/regr_point_sampler.sv
// Scans the colour-mask pixel stream and feeds the line-fit stage.
// Mask hits inside the row window [Y_MIN, Y_MAX] are optionally decimated
// and emitted as single-cycle point strobes. At end of frame one tabulate
// pulse is issued when any point was emitted, after which new frames are
// refused until the fit answers or the result wait times out.
//
// Ports
//   clk_in          : system clock
//   rst_in          : synchronous active-low reset
//   pixel_valid_in  : hcount_in / vcount_in / mask_in qualify this cycle
//   hcount_in       : pixel x
//   vcount_in       : pixel y
//   mask_in         : pixel matches the target colour
//   new_frame_in    : pulse with the first pixel of a frame
//   regr_valid_in   : fit result strobe
//   x_out, y_out    : last emitted point (held between strobes)
//   point_valid_out : point strobe
//   tabulate_out    : end-of-frame strobe to the fit
//   point_count_out : points emitted this frame, held until next frame start
//   busy_out        : high in TAB and WAIT_RESULT
//   dropped_out     : pulse, a new_frame_in was refused
//   timeout_out     : pulse, the result wait expired
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for new_frame_in
// COLLECT     | scanning pixels, emitting points, watching for EOF
// TAB         | one cycle: tabulate if any points, else straight to IDLE
// WAIT_RESULT | waiting for regr_valid_in, bounded by the timeout counter
module regr_point_sampler
  import regr_point_sampler_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 317,
  parameter int SKIP_LOG2   = 0,
  parameter int MAX_POINTS  = 8192,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pixel_valid_in,
  input  logic [X_W-1:0]    hcount_in,
  input  logic [Y_W-1:0]    vcount_in,
  input  logic              mask_in,
  input  logic              new_frame_in,
  input  logic              regr_valid_in,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic              point_valid_out,
  output logic              tabulate_out,
  output logic [PCNT_W-1:0] point_count_out,
  output logic              busy_out,
  output logic              dropped_out,
  output logic              timeout_out
);

  localparam int WAIT_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [HCNT_W-1:0] SKIP_MASK = HCNT_W'((1 << SKIP_LOG2) - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [HCNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [PCNT_W-1:0]   point_cnt_q, point_cnt_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                point_valid_q, point_valid_d;
  logic                tabulate_q, tabulate_d;
  logic                dropped_q, dropped_d;
  logic                timeout_q, timeout_d;

  logic                in_rows;
  logic                hit;
  logic                eof;
  logic                take_pixel;
  logic [HCNT_W-1:0]   hit_base;
  logic [PCNT_W-1:0]   pcnt_base;

  // Signed int compare keeps a zero Y_MIN from becoming a constant compare.
  assign in_rows = (int'(vcount_in) >= Y_MIN) && (int'(vcount_in) <= Y_MAX);
  assign hit     = pixel_valid_in && mask_in && in_rows;
  assign eof     = pixel_valid_in && (hcount_in == X_W'(H_ACTIVE - 1)) &&
                   (vcount_in == Y_W'(V_ACTIVE - 1));

  always_comb begin
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    point_cnt_d   = point_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    wait_cnt_d    = wait_cnt_q;
    point_valid_d = 1'b0;
    tabulate_d    = 1'b0;
    dropped_d     = 1'b0;
    timeout_d     = 1'b0;
    take_pixel    = 1'b0;
    hit_base      = hit_cnt_q;
    pcnt_base     = point_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (new_frame_in) begin
          // The frame-start pixel is sampled against freshly cleared counters.
          state_d    = ST_COLLECT;
          take_pixel = 1'b1;
          hit_base   = '0;
          pcnt_base  = '0;
        end
      end
      ST_COLLECT: begin
        if (new_frame_in) begin
          // Missing EOF: close this frame, refuse the one that just started.
          state_d   = ST_TAB;
          dropped_d = 1'b1;
        end else begin
          take_pixel = 1'b1;
        end
      end
      ST_TAB: begin
        dropped_d  = new_frame_in;
        wait_cnt_d = WAIT_LOAD;
        if (point_cnt_q != '0) begin
          tabulate_d = 1'b1;
          state_d    = ST_WAIT_RESULT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RESULT: begin
        dropped_d = new_frame_in;
        if (regr_valid_in) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_pixel) begin
      hit_cnt_d   = hit_base;
      point_cnt_d = pcnt_base;
      if (hit) begin
        hit_cnt_d = hit_base + HCNT_W'(1);
        // Decimation looks at the pre-increment hit index; the cap saturates.
        if (((hit_base & SKIP_MASK) == '0) && (pcnt_base < PCNT_W'(MAX_POINTS))) begin
          point_cnt_d   = pcnt_base + PCNT_W'(1);
          x_d           = hcount_in;
          y_d           = vcount_in;
          point_valid_d = 1'b1;
        end
      end
      if (eof) begin
        state_d = ST_TAB;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      hit_cnt_q     <= '0;
      point_cnt_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      wait_cnt_q    <= '0;
      point_valid_q <= 1'b0;
      tabulate_q    <= 1'b0;
      dropped_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_cnt_q     <= hit_cnt_d;
      point_cnt_q   <= point_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wait_cnt_q    <= wait_cnt_d;
      point_valid_q <= point_valid_d;
      tabulate_q    <= tabulate_d;
      dropped_q     <= dropped_d;
      timeout_q     <= timeout_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign point_valid_out = point_valid_q;
  assign tabulate_out    = tabulate_q;
  assign point_count_out = point_cnt_q;
  assign busy_out        = (state_q == ST_TAB) || (state_q == ST_WAIT_RESULT);
  assign dropped_out     = dropped_q;
  assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_regr_point_sampler.sv
module tb_regr_point_sampler;

  localparam int H = 16;
  localparam int V = 400;
  localparam int T = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        mask = 1'b0;
  logic        new_frame = 1'b0;
  logic        regr_valid = 1'b0;

  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic        a_pv, b_pv, a_tab, b_tab, a_busy, b_busy, a_drop, b_drop, a_to, b_to;
  logic [13:0] a_pc, b_pc;

  // dut_a: no decimation, cap of 4 points, rows 0..317
  regr_point_sampler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .Y_MIN(0), .Y_MAX(317),
    .SKIP_LOG2(0), .MAX_POINTS(4), .TIMEOUT_CYC(T)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .pixel_valid_in(pixel_valid),
    .hcount_in(hcount), .vcount_in(vcount), .mask_in(mask),
    .new_frame_in(new_frame), .regr_valid_in(regr_valid),
    .x_out(a_x), .y_out(a_y), .point_valid_out(a_pv), .tabulate_out(a_tab),
    .point_count_out(a_pc), .busy_out(a_busy), .dropped_out(a_drop),
    .timeout_out(a_to)
  );

  // dut_b: every 2nd hit, large cap, rows 2..399
  regr_point_sampler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .Y_MIN(2), .Y_MAX(399),
    .SKIP_LOG2(1), .MAX_POINTS(8192), .TIMEOUT_CYC(T)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .pixel_valid_in(pixel_valid),
    .hcount_in(hcount), .vcount_in(vcount), .mask_in(mask),
    .new_frame_in(new_frame), .regr_valid_in(regr_valid),
    .x_out(b_x), .y_out(b_y), .point_valid_out(b_pv), .tabulate_out(b_tab),
    .point_count_out(b_pc), .busy_out(b_busy), .dropped_out(b_drop),
    .timeout_out(b_to)
  );

  int total = 0;
  int bad = 0;

  logic [20:0] q_a[$];
  logic [20:0] q_b[$];
  logic [20:0] mon_a, mon_b;

  typedef struct {
    int h;
    int v;
    bit m;
    bit ea;
    bit eb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input bit m, input bit nf);
    pixel_valid = 1'b1;
    hcount      = 11'(h);
    vcount      = 10'(v);
    mask        = m;
    new_frame   = nf;
    step();
    pixel_valid = 1'b0;
    mask        = 1'b0;
    new_frame   = 1'b0;
  endtask

  task automatic expect_pt(input bit ea, input bit eb, input int h, input int v);
    if (ea) q_a.push_back({11'(h), 10'(v)});
    if (eb) q_b.push_back({11'(h), 10'(v)});
  endtask

  task automatic pulse_regr();
    regr_valid = 1'b1;
    step();
    regr_valid = 1'b0;
  endtask

  // Scoreboard: every point strobe must match the oldest expected point.
  always @(negedge clk) begin
    if (a_pv) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL a_point unexpected actual=(%0d,%0d) required=none", a_x, a_y);
      end else begin
        mon_a = q_a.pop_front();
        if ({a_x, a_y} !== mon_a) begin
          bad++;
          $display("FAIL a_point actual=(%0d,%0d) required=(%0d,%0d)",
                   a_x, a_y, mon_a[20:10], mon_a[9:0]);
        end
      end
    end
    if (b_pv) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL b_point unexpected actual=(%0d,%0d) required=none", b_x, b_y);
      end else begin
        mon_b = q_b.pop_front();
        if ({b_x, b_y} !== mon_b) begin
          bad++;
          $display("FAIL b_point actual=(%0d,%0d) required=(%0d,%0d)",
                   b_x, b_y, mon_b[20:10], mon_b[9:0]);
        end
      end
    end
    if (a_pv || a_tab) chk("a_pv_tab_excl", {63'd0, a_pv & a_tab}, 64'd0);
    if (b_pv || b_tab) chk("b_pv_tab_excl", {63'd0, b_pv & b_tab}, 64'd0);
  end

  initial begin
    int c;

    // h, v, mask, emit on dut_a, emit on dut_b
    vecs[0] = '{10,   5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{11,   5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{20,   6, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{5,  316, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{7,  318, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{6,  317, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8,    1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{9,    2, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3,    3, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{15, 399, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (3) step();
    chk("reset_a", {a_x, a_y, a_pv, a_tab, a_pc, a_busy, a_drop, a_to}, 64'd0);
    chk("reset_b", {b_x, b_y, b_pv, b_tab, b_pc, b_busy, b_drop, b_to}, 64'd0);
    rst = 1'b1;
    step();

    // three hits, latency and tabulate timing
    expect_pt(1, 1, 10, 5);
    pix(10, 5, 1, 1);
    chk("t1_lat_a0", a_pv, 1);
    chk("t1_lat_b0", b_pv, 1);
    step();
    expect_pt(1, 0, 20, 6);
    pix(20, 6, 1, 0);
    chk("t1_lat_a1", a_pv, 1);
    chk("t1_skip_b1", b_pv, 0);
    expect_pt(1, 1, 30, 7);
    pix(30, 7, 1, 0);
    step();
    pix(H - 1, V - 1, 0, 0);
    chk("t1_tab_early", a_tab, 0);
    chk("t1_busy_tab", a_busy, 1);
    step();
    chk("t1_tab_a", a_tab, 1);
    chk("t1_tab_b", b_tab, 1);
    step();
    chk("t1_tab_once", a_tab, 0);
    chk("t1_pc_a", a_pc, 3);
    chk("t1_pc_b", b_pc, 2);
    repeat (3) step();
    chk("t1_busy_wait", a_busy, 1);
    pulse_regr();
    chk("t1_idle_a", a_busy, 0);
    chk("t1_idle_b", b_busy, 0);
    chk("t1_pc_held", a_pc, 3);
    chk("t1_q_empty", q_a.size() + q_b.size(), 0);

    // table frame: row window, decimation, point cap
    for (int i = 0; i < 10; i++) begin
      expect_pt(vecs[i].ea, vecs[i].eb, vecs[i].h, vecs[i].v);
      pix(vecs[i].h, vecs[i].v, vecs[i].m, i == 0);
      chk($sformatf("vec%0d_pv_a", i), a_pv, vecs[i].ea);
      chk($sformatf("vec%0d_pv_b", i), b_pv, vecs[i].eb);
    end
    step();
    chk("t2_tab_a", a_tab, 1);
    chk("t2_tab_b", b_tab, 1);
    chk("t3_pc_cap_a", a_pc, 4);
    chk("t2_pc_b", b_pc, 4);
    pulse_regr();
    chk("t2_q_empty", q_a.size() + q_b.size(), 0);

    // empty frame: no tabulate, straight back to IDLE
    pix(0, 0, 0, 1);
    pix(H - 1, V - 1, 0, 0);
    chk("t3_empty_tab0", a_tab, 0);
    chk("t3_empty_busy_tab", a_busy, 1);
    step();
    chk("t3_empty_tab1", a_tab, 0);
    chk("t3_empty_idle", a_busy, 0);
    chk("t3_empty_pc", a_pc, 0);

    // dropped frame during WAIT_RESULT, then timeout
    expect_pt(1, 1, 1, 10);
    pix(1, 10, 1, 1);
    pix(H - 1, V - 1, 0, 0);
    step();
    chk("t4_tab", a_tab, 1);
    c = 0;
    pix(2, 3, 1, 1);
    c++;
    chk("t4_drop_a", a_drop, 1);
    chk("t4_drop_b", b_drop, 1);
    chk("t4_no_pt", a_pv, 0);
    while (c < T + 10 && !a_to) begin
      step();
      c++;
    end
    chk("t4_timeout_cycles", c, T);
    chk("t4_timeout_b", b_to, 1);
    step();
    chk("t4_timeout_pulse", a_to, 0);
    chk("t4_idle", a_busy, 0);

    // next frame accepted, then reset mid-COLLECT
    expect_pt(1, 1, 4, 4);
    pix(4, 4, 1, 1);
    chk("t4_next_frame", a_pv, 1);
    step();
    expect_pt(1, 0, 5, 4);
    pix(5, 4, 1, 0);
    rst = 1'b0;
    step();
    chk("t5_rst_a", {a_x, a_y, a_pv, a_tab, a_pc, a_busy, a_drop, a_to}, 64'd0);
    chk("t5_rst_b", {b_x, b_y, b_pv, b_tab, b_pc, b_busy, b_drop, b_to}, 64'd0);
    rst = 1'b1;
    pix(6, 4, 1, 0);
    chk("t5_abandoned", a_pv, 0);

    // hit on the EOF pixel: strobe then tabulate
    pix(0, 0, 0, 1);
    expect_pt(0, 1, H - 1, V - 1);
    pix(H - 1, V - 1, 1, 0);
    chk("t5_eof_pv_b", b_pv, 1);
    chk("t5_eof_pv_a", a_pv, 0);
    step();
    chk("t5_eof_tab_b", b_tab, 1);
    chk("t5_eof_tab_a", a_tab, 0);
    pulse_regr();
    chk("t5_idle_b", b_busy, 0);
    step();
    chk("final_q_empty", q_a.size() + q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
